vmem_scanout: RTL and testbench

VMEM_SCANOUT -- requirements
Module: vmem_scanout

---
 rtl/vmem_pkg.sv | 23 ++
 rtl/vmem_scanout_timing.sv | 78 +++++++
 rtl/vmem_scanout.sv | 141 ++++++++++++++
 tb/tb_vmem_scanout.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared constants for the vmem scanout block: default address width,
// default raster timing and the scanout FSM state encoding.
package vmem_pkg;

  localparam int VMEM_ADDRW = 14;

  localparam int H_ACTIVE = 128;
  localparam int H_FP     = 8;
  localparam int H_SYNC   = 16;
  localparam int H_BP     = 8;

  localparam int V_ACTIVE = 128;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

endpackage

// File: rtl/vmem_scanout_timing.sv
// Raster timing: h/v counters plus stage-0 active/sync/frame decode.
// Ports: clk, rst (sync, high), adv (count enable); outputs active,
// hsync/vsync (active-low, stage-0), first (pixel 0,0), last (end of
// frame); with VMEM_SCANOUT_SCALE2_EN also rewind (end of even line).
module vmem_scanout_timing #(
  parameter int H_ACTIVE = vmem_pkg::H_ACTIVE,
  parameter int H_FP     = vmem_pkg::H_FP,
  parameter int H_SYNC   = vmem_pkg::H_SYNC,
  parameter int H_BP     = vmem_pkg::H_BP,
  parameter int V_ACTIVE = vmem_pkg::V_ACTIVE,
  parameter int V_FP     = vmem_pkg::V_FP,
  parameter int V_SYNC   = vmem_pkg::V_SYNC,
  parameter int V_BP     = vmem_pkg::V_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic first,
`ifdef VMEM_SCANOUT_SCALE2_EN
  output logic rewind,
`endif
  output logic last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_last;
  logic          v_last;

  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (adv) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  assign active = (h < HW'(H_ACTIVE))
               && (v < VW'(V_ACTIVE));

  assign hsync = !((h >= HW'(HS_LO))
                && (h < HW'(HS_HI)));
  assign vsync = !((v >= VW'(VS_LO))
                && (v < VW'(VS_HI)));

  assign first = (h == '0) && (v == '0);
  assign last  = h_last && v_last;

`ifdef VMEM_SCANOUT_SCALE2_EN
  // Even source rows are shown twice, so the
  // row's last pixel steps back to its start.
  assign rewind = active && !v[0]
               && (h == HW'(H_ACTIVE - 1));
`endif

endmodule

// File: rtl/vmem_scanout.sv
// Video memory scanout: FSM, vmem address generator, output stage.
// Ports: clk_i, rst_i (sync, high), en_i; disp_raddr_o/disp_rdata_i
// (1-cycle read); pix_o, de_o, hsync_o, vsync_o, frame_start_o, busy_o.
// Macro VMEM_SCANOUT_SCALE2_EN enables 2x2 pixel doubling.
module vmem_scanout #(
  parameter int VMEM_ADDRW  = vmem_pkg::VMEM_ADDRW,
  parameter int VMEM_WDATAW = 3,
  parameter int H_ACTIVE    = vmem_pkg::H_ACTIVE,
  parameter int H_FP        = vmem_pkg::H_FP,
  parameter int H_SYNC      = vmem_pkg::H_SYNC,
  parameter int H_BP        = vmem_pkg::H_BP,
  parameter int V_ACTIVE    = vmem_pkg::V_ACTIVE,
  parameter int V_FP        = vmem_pkg::V_FP,
  parameter int V_SYNC      = vmem_pkg::V_SYNC,
  parameter int V_BP        = vmem_pkg::V_BP
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  output logic [VMEM_ADDRW-1:0]  disp_raddr_o,
  input  logic [VMEM_WDATAW-1:0] disp_rdata_i,
  output logic [VMEM_WDATAW-1:0] pix_o,
  output logic                   de_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   frame_start_o,
  output logic                   busy_o
);

  import vmem_pkg::*;

  if (VMEM_ADDRW < $clog2(H_ACTIVE * V_ACTIVE))
  begin : g_addrw_chk
    $error("VMEM_ADDRW too small for frame");
  end

`ifdef VMEM_SCANOUT_SCALE2_EN
  if ((H_ACTIVE % 2 != 0) || (V_ACTIVE % 2 != 0))
  begin : g_even_chk
    $error("H_ACTIVE and V_ACTIVE must be even");
  end
`endif

  state_t                state;
  logic [VMEM_ADDRW-1:0] addr;
  logic                  run;
  logic                  active;
  logic                  hs0;
  logic                  vs0;
  logic                  first;
  logic                  last;
  logic                  de_q;
  logic                  hs_q;
  logic                  vs_q;
  logic                  fs_q;
`ifdef VMEM_SCANOUT_SCALE2_EN
  logic                  rewind;
`endif

  assign run = (state != ST_IDLE);

  vmem_scanout_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (clk_i),
    .rst    (rst_i),
    .adv    (run),
    .active (active),
    .hsync  (hs0),
    .vsync  (vs0),
    .first  (first),
`ifdef VMEM_SCANOUT_SCALE2_EN
    .rewind (rewind),
`endif
    .last   (last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      addr  <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (en_i) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!en_i) state <= ST_STOP;
        end
        ST_STOP: begin
          if (en_i)      state <= ST_RUN;
          else if (last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      de_q <= run && active;
      hs_q <= run ? hs0 : 1'b1;
      vs_q <= run ? vs0 : 1'b1;
      fs_q <= run && first;

      // Clearing on the frame's last clock leaves
      // address 0 ready for pixel (0,0).
      if (run) begin
        if (last) begin
          addr <= '0;
`ifdef VMEM_SCANOUT_SCALE2_EN
        end else if (rewind) begin
          addr <= addr
                - VMEM_ADDRW'(H_ACTIVE / 2 - 1);
        end else if (active && u_timing.h[0]) begin
          addr <= addr + VMEM_ADDRW'(1);
`else
        end else if (active) begin
          addr <= addr + VMEM_ADDRW'(1);
`endif
        end
      end
    end
  end

  assign disp_raddr_o  = addr;
  assign de_o          = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign frame_start_o = fs_q;
  assign busy_o        = run;
  assign pix_o         = de_q ? disp_rdata_i : '0;

endmodule

// File: tb/tb_vmem_scanout.sv
// Bench for vmem_scanout on a 4x3 raster (H_TOTAL=7, V_TOTAL=6).
// Honours VMEM_SCANOUT_SCALE2_EN for expected addresses.
module tb_vmem_scanout;

  localparam int HA = 4;
  localparam int VA = 3;
  localparam int HT = 7;
  localparam int AW = 4;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] pix;
  logic          de;
  logic          hs;
  logic          vs;
  logic          fs;
  logic          busy;

  logic [DW-1:0] mem [0:15];

  vmem_scanout #(
    .VMEM_ADDRW  (AW),
    .VMEM_WDATAW (DW),
    .H_ACTIVE    (4),
    .H_FP        (1),
    .H_SYNC      (1),
    .H_BP        (1),
    .V_ACTIVE    (3),
    .V_FP        (1),
    .V_SYNC      (1),
    .V_BP        (1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .disp_raddr_o  (raddr),
    .disp_rdata_i  (rdata),
    .pix_o         (pix),
    .de_o          (de),
    .hsync_o       (hs),
    .vsync_o       (vs),
    .frame_start_o (fs),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[raddr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  function automatic int ea(int x, int y);
`ifdef VMEM_SCANOUT_SCALE2_EN
    return (y / 2) * (HA / 2) + x / 2;
`else
    return y * HA + x;
`endif
  endfunction

  function automatic int mv(int a);
    return (a * 5 + 3) % 8;
  endfunction

  typedef struct {
    logic rst;
    logic en;
    logic busy;
    logic de;
    logic hs;
    logic vs;
    logic fs;
    int   raddr;
    int   pix;
  } vec_t;

  vec_t tv [13];

  task automatic start_frame();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int h, v, ph, pv;
    int b_addr, b_de, b_pix, b_hs, b_vs, b_fs;
    int nde, nhs, nvs, nfs, b_busy;
    int last_fs, b_gap;
    logic eact;

    for (int i = 0; i < 16; i++) mem[i] = DW'(mv(i));

    tv[0]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
    tv[1]  = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
    tv[2]  = '{0, 1, 1, 0, 1, 1, 0, ea(0, 0), 0};
    tv[3]  = '{0, 1, 1, 1, 1, 1, 1, ea(1, 0),
               mv(ea(0, 0))};
    tv[4]  = '{0, 1, 1, 1, 1, 1, 0, ea(2, 0),
               mv(ea(1, 0))};
    tv[5]  = '{0, 1, 1, 1, 1, 1, 0, ea(3, 0),
               mv(ea(2, 0))};
    tv[6]  = '{0, 1, 1, 1, 1, 1, 0, ea(0, 1),
               mv(ea(3, 0))};
    tv[7]  = '{0, 1, 1, 0, 1, 1, 0, ea(0, 1), 0};
    tv[8]  = '{0, 1, 1, 0, 0, 1, 0, ea(0, 1), 0};
    tv[9]  = '{0, 1, 1, 0, 1, 1, 0, ea(0, 1), 0};
    tv[10] = '{0, 1, 1, 1, 1, 1, 0, ea(1, 1),
               mv(ea(0, 1))};
    tv[11] = '{0, 1, 1, 1, 1, 1, 0, ea(2, 1),
               mv(ea(1, 1))};
    tv[12] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};

    for (int i = 0; i < 13; i++) begin
      rst = tv[i].rst;
      en  = tv[i].en;
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy", i),
          32'(busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_de", i),
          32'(de), 32'(tv[i].de));
      chk($sformatf("v%0d_hs", i),
          32'(hs), 32'(tv[i].hs));
      chk($sformatf("v%0d_vs", i),
          32'(vs), 32'(tv[i].vs));
      chk($sformatf("v%0d_fs", i),
          32'(fs), 32'(tv[i].fs));
      chk($sformatf("v%0d_raddr", i),
          32'(raddr), 32'(tv[i].raddr));
      chk($sformatf("v%0d_pix", i),
          32'(pix), 32'(tv[i].pix));
    end

    // Full frame, en held high.
    start_frame();
    b_addr = 0; b_de = 0; b_pix = 0;
    b_hs = 0; b_vs = 0; b_fs = 0;
    nde = 0; nhs = 0; nvs = 0;
    for (int c = 0; c <= 42; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      h = c % HT;
      v = c / HT;
      if (c < 42 && h < HA && v < VA)
        if (raddr !== AW'(ea(h, v))) b_addr++;
      if (c >= 1) begin
        ph = (c - 1) % HT;
        pv = (c - 1) / HT;
        eact = (ph < HA) && (pv < VA);
        if (de !== eact) b_de++;
        if (de === 1'b1) begin
          nde++;
          if (pix !== DW'(mv(ea(ph, pv)))) b_pix++;
        end
        if (hs !== (ph != 5)) b_hs++;
        if (vs !== (pv != 4)) b_vs++;
        if (hs === 1'b0) nhs++;
        if (vs === 1'b0) nvs++;
        if (fs !== (c == 1)) b_fs++;
      end
    end
    chk("A_raddr_seq", 32'(b_addr), 0);
    chk("A_de_count", 32'(nde), 12);
    chk("A_de_pos", 32'(b_de), 0);
    chk("A_pix", 32'(b_pix), 0);
    chk("A_hs_count", 32'(nhs), 6);
    chk("A_hs_pos", 32'(b_hs), 0);
    chk("A_vs_count", 32'(nvs), 7);
    chk("A_vs_pos", 32'(b_vs), 0);
    chk("A_fs_pos", 32'(b_fs), 0);

    // en dropped on line 1: frame completes then idles.
    start_frame();
    nfs = 0; nde = 0; b_busy = 0;
    for (int c = 1; c <= 70; c++) begin
      if (c == 8) en = 1'b0;
      @(posedge clk); #1;
      if (busy !== (c <= 41)) b_busy++;
      if (fs === 1'b1) nfs++;
      if (de === 1'b1) nde++;
    end
    chk("B_busy", 32'(b_busy), 0);
    chk("B_fs_count", 32'(nfs), 1);
    chk("B_de_count", 32'(nde), 12);
    chk("B_idle_hs", 32'(hs), 1);
    chk("B_idle_vs", 32'(vs), 1);
    chk("B_idle_raddr", 32'(raddr), 0);

    // en toggled within a frame: no gap between frames.
    start_frame();
    nfs = 0; b_busy = 0; b_gap = 0; last_fs = -1;
    for (int c = 1; c <= 130; c++) begin
      if (c == 10) en = 1'b0;
      if (c == 20) en = 1'b1;
      @(posedge clk); #1;
      if (busy !== 1'b1) b_busy++;
      if (fs === 1'b1) begin
        nfs++;
        if (last_fs < 0) begin
          if (c != 1) b_gap++;
        end else if (c - last_fs != 42) begin
          b_gap++;
        end
        last_fs = c;
      end
    end
    chk("C_busy", 32'(b_busy), 0);
    chk("C_fs_count", 32'(nfs), 4);
    chk("C_fs_gap", 32'(b_gap), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
